edge_points: RTL and testbench

EDGE_POINTS -- requirements
Module: edge_points

---
 rtl/hough_pkg.sv | 19 +
 rtl/point_fifo.sv | 62 ++++++
 rtl/edge_points.sv | 129 ++++++++++++
 tb/tb_edge_points.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hough_pkg.sv
// Shared types for the edge-point extraction path: coordinate width, point record, scan FSM states.
// No logic here; imported by edge_points and point_fifo.
package hough_pkg;

  localparam int COORD_W = 8;

  typedef logic [COORD_W-1:0] coord_t;

  typedef struct packed {
    coord_t x;
    coord_t y;
  } point_t;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_SCAN = 1'b1
  } state_t;

endpackage

// File: rtl/point_fifo.sv
// Synchronous point FIFO, DEPTH entries (power of two); head visible the cycle after the write.
// A push into a full FIFO is taken only when a pop happens in the same cycle; otherwise it is ignored.
module point_fifo
  import hough_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic   clk_i,
  input  logic   rst_i,
  input  logic   push_i,
  input  point_t push_dat_i,
  input  logic   pop_i,
  output point_t head_dat_o,
  output logic   full_o,
  output logic   empty_o
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;

  point_t        mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q;
  logic [AW-1:0] rd_ptr_q;
  logic [CW-1:0] count_q;
  logic          wr_en;
  logic          rd_en;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CW'(DEPTH));
  assign rd_en   = pop_i && !empty_o;
  assign wr_en   = push_i && (!full_o || rd_en);

  // Head is forced to zero when empty so the coordinate outputs read 0 out of reset.
  assign head_dat_o = empty_o ? '0 : mem_q[rd_ptr_q];

  always_ff @(posedge clk_i) begin
    if (wr_en) begin
      mem_q[wr_ptr_q] <= push_dat_i;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (wr_en) begin
        wr_ptr_q <= wr_ptr_q + AW'(1);
      end
      if (rd_en) begin
        rd_ptr_q <= rd_ptr_q + AW'(1);
      end
      unique case ({wr_en, rd_en})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/edge_points.sv
// Raster-scans edge magnitudes, emits (x,y) of pixels above threshold; point reaches PointValid 2 cycles after its pixel.
// Downstream stalls back up into the FIFO; a point arriving at a full FIFO without a same-cycle pop is dropped and flagged.
module edge_points
  import hough_pkg::*;
#(
  parameter int DEPTH           = 16,
  parameter bit SUPPRESS_BORDER = 1'b1
) (
  input  logic               Clk,
  input  logic               Reset,
  input  logic [COORD_W-1:0] PixelIn,
  input  logic               FrameIn,
  input  logic               LineIn,
  input  logic [COORD_W-1:0] Width,
  input  logic [COORD_W-1:0] Height,
  input  logic [COORD_W-1:0] Threshold,
  output logic [COORD_W-1:0] PointX,
  output logic [COORD_W-1:0] PointY,
  output logic               PointValid,
  input  logic               PointReady,
  output logic               FrameDone,
  output logic               Overflow
);

  state_t state_q;
  coord_t x_q, y_q, x_d, y_d;
  coord_t w_q, h_q, thr_q;
  logic   pend_vld_q;
  point_t pend_q;
  logic   done_q;
  logic   ovf_q;

  logic   frame_acc;
  logic   scan;
  logic   active;
  coord_t w_eff, h_eff, thr_eff;
  logic   border_ok;
  logic   qualify;
  logic   last_px;

  point_t head;
  logic   fifo_full;
  logic   fifo_empty;
  logic   pop;
  logic   drop;

  // A frame strobe with a zero dimension is treated as if it never arrived.
  assign frame_acc = FrameIn && (Width != '0) && (Height != '0);
  assign scan      = (state_q == ST_SCAN);
  assign active    = frame_acc || scan;
  assign w_eff     = frame_acc ? Width     : w_q;
  assign h_eff     = frame_acc ? Height    : h_q;
  assign thr_eff   = frame_acc ? Threshold : thr_q;

  // Coordinates of the pixel currently on PixelIn.
  always_comb begin
    x_d = x_q;
    y_d = y_q;
    if (frame_acc) begin
      x_d = '0;
      y_d = '0;
    end else if (scan && LineIn) begin
      x_d = '0;
      y_d = (y_q >= h_q - 8'd1) ? y_q : y_q + 8'd1;
    end else if (scan) begin
      x_d = (x_q >= w_q) ? w_q : x_q + 8'd1;
    end
  end

  assign border_ok = !SUPPRESS_BORDER || ((x_d != '0) && (y_d != '0));
  assign qualify   = active && (x_d < w_eff) && (PixelIn > thr_eff) && border_ok;
  assign last_px   = active && (x_d == w_eff - 8'd1) && (y_d == h_eff - 8'd1);

  assign pop  = !fifo_empty && PointReady;
  assign drop = pend_vld_q && fifo_full && !pop;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q    <= ST_IDLE;
      x_q        <= '0;
      y_q        <= '0;
      w_q        <= '0;
      h_q        <= '0;
      thr_q      <= '0;
      pend_vld_q <= 1'b0;
      pend_q     <= '0;
      done_q     <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      if (last_px) begin
        state_q <= ST_IDLE;
      end else if (frame_acc) begin
        state_q <= ST_SCAN;
      end
      if (frame_acc) begin
        w_q   <= Width;
        h_q   <= Height;
        thr_q <= Threshold;
      end
      x_q        <= x_d;
      y_q        <= y_d;
      pend_vld_q <= qualify;
      pend_q     <= '{x: x_d, y: y_d};
      done_q     <= last_px;
      // A drop in the same cycle as a new frame still leaves the flag set.
      ovf_q      <= drop || (ovf_q && !frame_acc);
    end
  end

  point_fifo #(
    .DEPTH(DEPTH)
  ) u_point_fifo (
    .clk_i      (Clk),
    .rst_i      (Reset),
    .push_i     (pend_vld_q),
    .push_dat_i (pend_q),
    .pop_i      (pop),
    .head_dat_o (head),
    .full_o     (fifo_full),
    .empty_o    (fifo_empty)
  );

  assign PointValid = !fifo_empty;
  assign PointX     = head.x;
  assign PointY     = head.y;
  assign FrameDone  = done_q;
  assign Overflow   = ovf_q;

endmodule

// File: tb/tb_edge_points.sv
// Directed and randomized bench for edge_points; expected points come from a per-frame image scan model.
module tb_edge_points;

  localparam int DEPTH = 4;

  logic       Clk = 1'b0;
  logic       Reset;
  logic [7:0] PixelIn;
  logic       FrameIn;
  logic       LineIn;
  logic [7:0] Width;
  logic [7:0] Height;
  logic [7:0] Threshold;
  logic [7:0] PointX;
  logic [7:0] PointY;
  logic       PointValid;
  logic       PointReady;
  logic       FrameDone;
  logic       Overflow;

  int          checks = 0;
  int          passes = 0;
  bit          rand_ready = 1'b0;
  int          exp_total;
  logic [15:0] got_q[$];
  logic [15:0] exp_q[$];
  logic [7:0]  img [0:15][0:15];

  always #5 Clk = ~Clk;

  edge_points #(
    .DEPTH(DEPTH),
    .SUPPRESS_BORDER(1'b1)
  ) dut (
    .Clk(Clk), .Reset(Reset), .PixelIn(PixelIn), .FrameIn(FrameIn), .LineIn(LineIn),
    .Width(Width), .Height(Height), .Threshold(Threshold),
    .PointX(PointX), .PointY(PointY), .PointValid(PointValid), .PointReady(PointReady),
    .FrameDone(FrameDone), .Overflow(Overflow)
  );

  // Record every point the DUT hands over.
  always @(negedge Clk)
    if (!Reset && PointValid && PointReady) got_q.push_back({PointX, PointY});

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, observed timeout required completion");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
  endtask

  task automatic drive_pixel(input logic [7:0] pix, input logic f, input logic l);
    PixelIn = pix;
    FrameIn = f;
    LineIn  = l;
    if (rand_ready) PointReady = 1'($urandom_range(0, 1));
    @(posedge Clk);
    #1;
    FrameIn   = 1'b0;
    LineIn    = 1'b0;
    Width     = 8'($urandom);
    Height    = 8'($urandom);
    Threshold = 8'($urandom);
  endtask

  task automatic clear_img();
    for (int y = 0; y < 16; y++)
      for (int x = 0; x < 16; x++) img[y][x] = 8'd0;
  endtask

  task automatic fill_img(input logic [7:0] v);
    for (int y = 0; y < 16; y++)
      for (int x = 0; x < 16; x++) img[y][x] = v;
  endtask

  // Points are all interior pixels strictly above threshold, in raster order; only the first cap are kept.
  task automatic build_exp(input int w, input int h, input logic [7:0] thr, input int cap);
    exp_q.delete();
    exp_total = 0;
    for (int y = 0; y < h; y++)
      for (int x = 0; x < w; x++)
        if (img[y][x] > thr && x != 0 && y != 0) begin
          exp_total++;
          if (exp_q.size() < cap) exp_q.push_back({8'(x), 8'(y)});
        end
  endtask

  task automatic drive_frame(input int w, input int h, input logic [7:0] thr, input int blank_max,
                             input string tag);
    int nb;
    for (int y = 0; y < h; y++) begin
      for (int x = 0; x < w; x++) begin
        if (x == 0 && y == 0) begin
          Width = 8'(w); Height = 8'(h); Threshold = thr;
        end
        drive_pixel(img[y][x], (x == 0 && y == 0), (x == 0));
        check({tag, "_done"}, FrameDone, (x == w - 1 && y == h - 1));
      end
      if (y < h - 1) begin
        nb = $urandom_range(0, blank_max);
        for (int b = 0; b < nb; b++) begin
          drive_pixel(8'($urandom), 1'b0, 1'b0);
          check({tag, "_done_blank"}, FrameDone, 0);
        end
      end
    end
  endtask

  task automatic drain(input int n);
    rand_ready = 1'b0;
    PointReady = 1'b1;
    for (int i = 0; i < n; i++) drive_pixel(8'd0, 1'b0, 1'b0);
  endtask

  task automatic compare_pts(input string tag);
    check({tag, "_count"}, got_q.size(), exp_q.size());
    foreach (exp_q[i])
      if (i < got_q.size()) check({tag, "_pt"}, got_q[i], exp_q[i]);
    got_q.delete();
  endtask

  initial begin
    int w, h, x, y;
    logic [7:0] thr;
    bit sparse;

    Reset = 1'b1; PixelIn = 0; FrameIn = 0; LineIn = 0;
    Width = 0; Height = 0; Threshold = 0; PointReady = 1'b0;
    repeat (3) @(posedge Clk);
    #1;
    check("rst_valid", PointValid, 0);
    check("rst_x", PointX, 0);
    check("rst_y", PointY, 0);
    check("rst_done", FrameDone, 0);
    check("rst_ovf", Overflow, 0);
    Reset = 1'b0;
    @(posedge Clk);
    #1;
    check("post_rst_valid", PointValid, 0);

    // Single point at (2,1): valid exactly two cycles after its pixel, done after the 12th pixel.
    clear_img(); img[1][2] = 8'd50; PointReady = 1'b1;
    for (int i = 0; i < 12; i++) begin
      x = i % 4; y = i / 4;
      if (i == 0) begin Width = 8'd4; Height = 8'd3; Threshold = 8'd10; end
      drive_pixel(img[y][x], (i == 0), (x == 0));
      check("t2_valid", PointValid, (i == 7));
      if (i == 7) begin
        check("t2_x", PointX, 2);
        check("t2_y", PointY, 1);
      end
      check("t2_done", FrameDone, (i == 11));
    end
    drive_pixel(8'd0, 1'b0, 1'b0);
    check("t2_done_clear", FrameDone, 0);
    drain(4);
    build_exp(4, 3, 8'd10, 1000);
    compare_pts("t2");

    // Equal to threshold is not an edge; one above is.
    clear_img(); img[1][1] = 8'd10;
    drive_frame(4, 3, 8'd10, 0, "t3a");
    drain(6); build_exp(4, 3, 8'd10, 1000); compare_pts("t3a");
    img[1][1] = 8'd11;
    drive_frame(4, 3, 8'd10, 0, "t3b");
    drain(6); build_exp(4, 3, 8'd10, 1000); compare_pts("t3b");

    // All bright with border suppression, blanking between lines.
    fill_img(8'd255);
    drive_frame(4, 3, 8'd10, 2, "t4");
    drain(6); build_exp(4, 3, 8'd10, 1000); compare_pts("t4");

    // Stalled downstream: FIFO fills, rest dropped; next frame clears the flag but keeps contents.
    PointReady = 1'b0;
    fill_img(8'd255);
    drive_frame(4, 3, 8'd10, 0, "t5");
    drive_pixel(8'd0, 1'b0, 1'b0);
    drive_pixel(8'd0, 1'b0, 1'b0);
    build_exp(4, 3, 8'd10, DEPTH);
    check("t5_ovf", Overflow, (exp_total > DEPTH));
    check("t5_valid", PointValid, 1);
    check("t5_head", {PointX, PointY}, exp_q[0]);
    Width = 8'd4; Height = 8'd3; Threshold = 8'd10;
    drive_pixel(8'd0, 1'b1, 1'b1);
    check("t5_ovf_clear", Overflow, 0);
    for (int i = 1; i < 12; i++) drive_pixel(8'd0, 1'b0, (i % 4 == 0));
    check("t5_retained", PointValid, 1);
    drain(8);
    compare_pts("t5");

    // Full FIFO, pop and push in the same cycle: nothing lost.
    PointReady = 1'b0;
    clear_img();
    img[1][1] = 8'd200; img[1][2] = 8'd200; img[1][3] = 8'd200;
    img[2][1] = 8'd200; img[2][2] = 8'd200;
    for (int i = 0; i < 12; i++) begin
      x = i % 4; y = i / 4;
      if (i == 0) begin Width = 8'd4; Height = 8'd3; Threshold = 8'd10; end
      if (i == 11) PointReady = 1'b1;
      drive_pixel(img[y][x], (i == 0), (x == 0));
      if (i == 10) check("t6_full_valid", PointValid, 1);
    end
    check("t6_ovf", Overflow, 0);
    drain(10);
    check("t6_ovf_after", Overflow, 0);
    build_exp(4, 3, 8'd10, 1000);
    compare_pts("t6");

    // Reset mid-frame with three queued points and one in flight.
    PointReady = 1'b0;
    clear_img();
    img[1][1] = 8'd90; img[1][2] = 8'd90; img[1][3] = 8'd90; img[2][1] = 8'd90;
    for (int i = 0; i < 10; i++) begin
      x = i % 4; y = i / 4;
      if (i == 0) begin Width = 8'd4; Height = 8'd3; Threshold = 8'd10; end
      drive_pixel(img[y][x], (i == 0), (x == 0));
      if (i == 8) begin
        check("t7_queued_valid", PointValid, 1);
        check("t7_queued_head", {PointX, PointY}, 16'h0101);
      end
    end
    Reset = 1'b1;
    #1;
    check("t7_async_valid", PointValid, 0);
    @(posedge Clk);
    #1;
    check("t7_rst_valid", PointValid, 0);
    check("t7_rst_x", PointX, 0);
    Reset = 1'b0;
    PointReady = 1'b1;
    for (int i = 0; i < 6; i++) begin
      drive_pixel(8'd255, 1'b0, (i % 2 == 0));
      check("t7_no_done", FrameDone, 0);
      check("t7_no_valid", PointValid, 0);
    end
    check("t7_no_points", got_q.size(), 0);
    got_q.delete();
    clear_img(); img[2][2] = 8'd99;
    drive_frame(4, 3, 8'd10, 1, "t7b");
    drain(6); build_exp(4, 3, 8'd10, 1000); compare_pts("t7b");

    // New frame strobe mid-scan restarts the raster; already captured points survive.
    PointReady = 1'b1;
    fill_img(8'd255);
    for (int i = 0; i < 6; i++) begin
      x = i % 4;
      if (i == 0) begin Width = 8'd4; Height = 8'd3; Threshold = 8'd10; end
      drive_pixel(8'd255, (i == 0), (x == 0));
      check("t8_done_a", FrameDone, 0);
    end
    clear_img(); img[2][3] = 8'd77;
    drive_frame(4, 3, 8'd10, 1, "t8b");
    drain(6);
    build_exp(4, 3, 8'd10, 1000);
    exp_q.push_front(16'h0101);
    compare_pts("t8");

    // Zero-sized frame strobes are ignored.
    for (int k = 0; k < 2; k++) begin
      Width = (k == 0) ? 8'd0 : 8'd4; Height = (k == 0) ? 8'd3 : 8'd0; Threshold = 8'd0;
      drive_pixel(8'd255, 1'b1, 1'b1);
      for (int i = 0; i < 5; i++) begin
        drive_pixel(8'd255, 1'b0, (i == 2));
        check("t9_done", FrameDone, 0);
      end
    end
    drain(4);
    check("t9_points", got_q.size(), 0);
    got_q.delete();

    // Randomized frames: dense images with free-flowing output, sparse images with random stalls.
    for (int f = 0; f < 16; f++) begin
      w = $urandom_range(1, 8);
      h = $urandom_range(1, 6);
      thr = 8'($urandom_range(0, 254));
      sparse = (f % 2 == 1);
      for (int yy = 0; yy < h; yy++)
        for (int xx = 0; xx < w; xx++)
          img[yy][xx] = sparse ? 8'($urandom_range(0, int'(thr))) : 8'($urandom);
      if (sparse)
        for (int k = 0; k < 4; k++)
          img[$urandom_range(0, h - 1)][$urandom_range(0, w - 1)] = 8'($urandom_range(int'(thr) + 1, 255));
      PointReady = 1'b1;
      rand_ready = sparse;
      drive_frame(w, h, thr, 3, "rnd");
      drain(12);
      build_exp(w, h, thr, 1000);
      check("rnd_ovf", Overflow, 0);
      compare_pts("rnd");
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
